restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 105 ++++++++++
 tb/tb_restoring_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// divide-by-zero shortcut that reports all-ones quotient and the dividend as remainder.
module restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // One restoring step. The true difference is below the divisor whenever it is
  // kept, so a WIDTH-bit subtraction is exact in that case.
  always_comb begin
    r_sh    = {rem_q, quo_q[WIDTH-1]};
    diff    = r_sh[WIDTH-1:0] - div_q;
    ge      = (r_sh >= {1'b0, div_q});
    rem_nxt = ge ? diff : r_sh[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q     <= StDone;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= StCalc;
              busy    <= 1'b1;
              rem_q   <= '0;
              quo_q   <= dividend;
              div_q   <= divisor;
              cnt_q   <= CntW'(WIDTH);
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at WIDTH=4.
module tb_restoring_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int passes = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one accepting edge.
  task automatic start_div(input int a, input int b);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Bounded wait for done; cycles = -1 when the bound expires.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
      if (busy) busy_cnt++;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    checks++; if ({busy, done, div_by_zero} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); else passes++;
    checks++; if ({quotient, remainder} !== '0)
      $display("FAIL reset_results got %h want 00", {quotient, remainder}); else passes++;
    #2 rst = 1'b0;
    tick();
    checks++; if ({busy, done} !== 2'b00)
      $display("FAIL reset_release got %b want 00", {busy, done}); else passes++;
  endtask

  task automatic test_basic();
    int cyc, bc;
    start_div(13, 3);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_first got %b want 1", busy); else passes++;
    wait_done(cyc, bc);
    checks++; if (cyc !== 4) $display("FAIL basic_latency got %0d want 4", cyc); else passes++;
    checks++; if (bc !== 4) $display("FAIL basic_busy_cycles got %0d want 4", bc); else passes++;
    checks++; if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0)
      $display("FAIL basic_result got q=%0d r=%0d z=%b want q=4 r=1 z=0",
               quotient, remainder, div_by_zero); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passes++;
  endtask

  task automatic test_boundary();
    int cyc, bc;
    int va[3] = '{15, 2, 0};
    int vb[3] = '{1, 7, 5};
    int eq[3] = '{15, 0, 0};
    int er[3] = '{0, 2, 0};
    for (int i = 0; i < 3; i++) begin
      start_div(va[i], vb[i]);
      wait_done(cyc, bc);
      checks++; if (cyc !== 4 || quotient !== W'(eq[i]) || remainder !== W'(er[i]))
        $display("FAIL boundary_%0d_%0d got q=%0d r=%0d cyc=%0d want q=%0d r=%0d cyc=4",
                 va[i], vb[i], quotient, remainder, cyc, eq[i], er[i]); else passes++;
      tick();
    end
  endtask

  task automatic test_div_zero();
    int cyc, bc;
    start_div(9, 0);
    wait_done(cyc, bc);
    checks++; if (cyc !== 0 || bc !== 0)
      $display("FAIL dbz_timing got cyc=%0d busy=%0d want 0 0", cyc, bc); else passes++;
    checks++; if (quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== 1'b1)
      $display("FAIL dbz_result got q=%0d r=%0d z=%b want q=15 r=9 z=1",
               quotient, remainder, div_by_zero); else passes++;
    tick();
    checks++; if (done !== 1'b0 || div_by_zero !== 1'b1)
      $display("FAIL dbz_after got done=%b z=%b want 0 1", done, div_by_zero); else passes++;
  endtask

  task automatic test_start_while_busy();
    int cyc, bc, extra;
    start_div(13, 3);
    tick();
    start_div(6, 2);
    wait_done(cyc, bc);
    checks++; if (cyc !== 2 || quotient !== 4'd4 || remainder !== 4'd1)
      $display("FAIL busy_start got q=%0d r=%0d cyc=%0d want q=4 r=1 cyc=2",
               quotient, remainder, cyc); else passes++;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL busy_no_second got %0d want 0", extra); else passes++;
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    start_div(13, 3);
    wait_done(cyc, bc);
    start_div(14, 4);
    checks++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); else passes++;
    checks++; if (quotient !== 4'd4 || remainder !== 4'd1)
      $display("FAIL b2b_hold got q=%0d r=%0d want q=4 r=1", quotient, remainder); else passes++;
    wait_done(cyc, bc);
    checks++; if (cyc !== 4 || quotient !== 4'd3 || remainder !== 4'd2)
      $display("FAIL b2b_result got q=%0d r=%0d cyc=%0d want q=3 r=2 cyc=4",
               quotient, remainder, cyc); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc, bc, seen;
    start_div(13, 3);
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, div_by_zero, quotient, remainder} !== '0)
      $display("FAIL mid_reset got %b want all zero",
               {busy, done, div_by_zero, quotient, remainder}); else passes++;
    tick();
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL mid_no_done got %0d want 0", seen); else passes++;
    start_div(13, 3);
    wait_done(cyc, bc);
    checks++; if (cyc !== 4 || quotient !== 4'd4 || remainder !== 4'd1)
      $display("FAIL mid_recover got q=%0d r=%0d cyc=%0d want q=4 r=1 cyc=4",
               quotient, remainder, cyc); else passes++;
    tick();
  endtask

  task automatic test_exhaustive();
    int cyc, bc, eq, er;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        start_div(a, b);
        wait_done(cyc, bc);
        checks++; if (cyc < 0 || quotient !== W'(eq) || remainder !== W'(er) ||
                      div_by_zero !== (b == 0))
          $display("FAIL sweep_%0d_%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                   a, b, quotient, remainder, div_by_zero, eq, er, (b == 0)); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
